project_mux_ctrl: RTL and testbench
===================================

// Module: project_mux_ctrl
// PURPOSE
//   Parametrised successor to the user-area project selector. Routes io pads to one of NUM_PROJECTS
//   projects and owns a Wishbone register bank. New here: byte-lane writes, readback of every register,
//   a status register, and ack for any address in the bank. Switching projects runs a break-before-make
//   sequence: pads blanked and projects held in reset for SWITCH_GAP cycles. Sits between the user-area
//   pads/Wishbone and the project instances.
// PARAMETERS
//   NUM_PROJECTS  8             number of selectable projects (1..16)
//   IO_PADS       38            pad count (33..64)
//   BASE_ADDR     32'h3000_0000 register bank base; bank spans BASE_ADDR..BASE_ADDR+0xFF
//   SWITCH_GAP    4             blank/reset cycles on project change (>=1)
// PORTS
//   wb_clk_i      in   1                    clock
//   wb_rstn_i     in   1                    synchronous reset, active-low
//   wbs_stb_i, wbs_cyc_i, wbs_we_i  in 1 each  Wishbone strobe/cycle/write-enable
//   wbs_sel_i     in   4                    byte lanes
//   wbs_adr_i     in   32                   address
//   wbs_dat_i     in   32                   write data
//   wbs_ack_o     out  1                    ack (registered)
//   wbs_dat_o     out  32                   read data (registered)
//   io_in         in   IO_PADS              pad inputs
//   io_out        out  IO_PADS              pad outputs
//   io_oeb        out  IO_PADS              pad output-enable, active-low
//   proj_io_out   in   NUM_PROJECTS*IO_PADS project k drives bits [k*IO_PADS +: IO_PADS]
//   proj_io_in    out  NUM_PROJECTS*IO_PADS gated pad inputs per project
//   proj_rst_o    out  NUM_PROJECTS         active-high reset per project
// BEHAVIOUR
//   Reset (wb_rstn_i=0 at an edge): active=0, oeb_reg all ones, state=RUN, ack=0, dat_o=0;
//     proj_rst_o all ones during reset and for one cycle after.
//   Registers (offset from BASE_ADDR, R/W unless noted; a write updates only bytes with sel set):
//     0x00 ACTIVE [7:0] requested project.  0x04 OEB_LO [31:0].  0x08 OEB_HI [IO_PADS-33:0].
//     0x0C STATUS (RO) [7:0]=current active, [8]=switching, [9]=active out of range. Writes ignored, acked.
//   Valid = cyc&stb. Address in bank and valid, ack=0 -> ack=1 next edge, dat_o = register value
//     (0 for unmapped offsets or writes). Ack is a single-cycle pulse. Next ack needs valid again
//     with ack low. Addresses outside the bank never ack.
//   FSM RUN/DRAIN:
//     RUN: io_out = proj_io_out[active]; io_oeb = oeb_reg; proj_io_in[active] = io_in, others 0;
//       proj_rst_o[active]=0, others 1.
//     An ACTIVE write whose byte0 differs from active -> DRAIN, counter = SWITCH_GAP-1, pending stored.
//       Same value: no transition.
//     DRAIN: io_out=0, io_oeb all ones, every proj_io_in=0, proj_rst_o all ones.
//       Counter decrements each cycle. At 0: active <= pending, go to RUN.
//     A new ACTIVE write during DRAIN updates pending and reloads the counter.
//   Out-of-range active (>=NUM_PROJECTS) in RUN: io_out=0, io_oeb all ones, all projects in reset.
//   OEB writes take effect the cycle after ack, in both states; in DRAIN they are masked until RUN.
//   io_out/io_oeb/proj_io_in are combinational from registered state; no input-to-output path via wb.
//   Reset mid-DRAIN: abandon switch, active=0.
// STRUCTURE
//   Package project_mux_pkg: register offset localparams, STATUS bit indices, state enum (RUN, DRAIN).
//   One sub-module: project_mux_regs (Wishbone decode, byte-lane register bank, ack/readback).
//   Top holds FSM, counter, pad muxing.
// TESTING
//   Reset, read 0x0C -> 0x000; io_oeb=all ones; proj_rst_o all ones then 0xFE one cycle after release.
//   Write ACTIVE=3 -> ack in 1 cycle; STATUS[8]=1 for 4 cycles, io_out=0; then io_out=proj3 out,
//     proj_rst_o=~(1<<3).
//   Write OEB_LO=0x0000_FF00 with sel=4'b0010 -> readback 0xFFFF_FFFF... only byte1 changed (0x..00..).
//   Write ACTIVE=9 (NUM_PROJECTS=8) -> after gap STATUS=0x209, io_out=0, io_oeb all ones.
//   Write ACTIVE=2 then ACTIVE=5 two cycles later -> counter reloads; lands on 5 after 4 more cycles,
//     never exposes 2.
//   Access BASE+0x40 -> ack, dat_o=0; access BASE+0x100 -> no ack.

Source files
------------

// File: rtl/project_mux_pkg.sv
// Shared definitions for the user-area project selector: register map, STATUS layout, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package project_mux_pkg;

    // Register offsets within the 256-byte bank
    localparam logic [7:0] OFF_ACTIVE = 8'h00;
    localparam logic [7:0] OFF_OEB_LO = 8'h04;
    localparam logic [7:0] OFF_OEB_HI = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    // STATUS register layout: [7:0] current active project
    localparam int ST_BIT_SWITCHING = 8;
    localparam int ST_BIT_RANGE     = 9;
    localparam int STATUS_W         = 10;

    // Break-before-make sequencing
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Replace only the byte lanes whose select bit is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/project_mux_regs.sv
// Wishbone slave for the selector register bank: decode, byte-lane writes, readback.
// Latency: ack and read data registered, one cycle after a valid in-bank request.
// Backpressure: none; ack is a one-cycle pulse, a held request re-acks every other cycle.
module project_mux_regs
    import project_mux_pkg::*;
#(
    parameter int          IO_PADS   = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [STATUS_W-1:0] status,
    output logic [IO_PADS-1:0]  oeb_reg,
    output logic                act_wr,
    output logic [7:0]          act_wr_dat
);

    localparam int HI_W = IO_PADS - 32;

    logic             valid;
    logic             in_bank;
    logic             accept;
    logic [7:0]       off;
    logic [7:0]       active_req;
    logic [31:0]      oeb_lo;
    logic [HI_W-1:0]  oeb_hi;
    logic [31:0]      rd_val;
    logic [31:0]      lo_merged;
    logic [31:0]      hi_merged;

    assign valid     = wbs_cyc_i & wbs_stb_i;
    assign in_bank   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // A request already being acked is not accepted again until ack drops
    assign accept    = valid & in_bank & ~wbs_ack_o;
    assign off       = wbs_adr_i[7:0];
    assign lo_merged = byte_merge(oeb_lo, wbs_dat_i, wbs_sel_i);
    assign hi_merged = byte_merge(32'(oeb_hi), wbs_dat_i, wbs_sel_i);

    // The FSM sees the ACTIVE write on the same edge the register captures it
    assign act_wr     = accept & wbs_we_i & wbs_sel_i[0] & (off == OFF_ACTIVE);
    assign act_wr_dat = wbs_dat_i[7:0];
    assign oeb_reg    = {oeb_hi, oeb_lo};

    // Readback mux; unmapped offsets read as zero
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_ACTIVE: rd_val = {24'd0, active_req};
            OFF_OEB_LO: rd_val = oeb_lo;
            OFF_OEB_HI: rd_val = 32'(oeb_hi);
            OFF_STATUS: rd_val = 32'(status);
            default:    rd_val = '0;
        endcase
    end

    // Ack/readback pipeline and byte-lane register writes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            active_req <= '0;
            oeb_lo     <= '1;
            oeb_hi     <= '1;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept && !wbs_we_i) ? rd_val : '0;
            if (accept && wbs_we_i) begin
                case (off)
                    OFF_ACTIVE: if (wbs_sel_i[0]) active_req <= wbs_dat_i[7:0];
                    OFF_OEB_LO: oeb_lo <= lo_merged;
                    OFF_OEB_HI: oeb_hi <= hi_merged[HI_W-1:0];
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: rtl/project_mux_ctrl.sv
// Routes user-area pads to one selected project; break-before-make on every project change.
// Latency: pad routing combinational from registered state; switch completes SWITCH_GAP cycles after the write.
// Backpressure: none; a new selection during a switch restarts the blanking window.
module project_mux_ctrl
    import project_mux_pkg::*;
#(
    parameter int          NUM_PROJECTS = 8,
    parameter int          IO_PADS      = 38,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          SWITCH_GAP   = 4
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rstn_i,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_we_i,
    input  logic [3:0]                      wbs_sel_i,
    input  logic [31:0]                     wbs_adr_i,
    input  logic [31:0]                     wbs_dat_i,
    output logic                            wbs_ack_o,
    output logic [31:0]                     wbs_dat_o,
    input  logic [IO_PADS-1:0]              io_in,
    output logic [IO_PADS-1:0]              io_out,
    output logic [IO_PADS-1:0]              io_oeb,
    input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
    output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
    output logic [NUM_PROJECTS-1:0]         proj_rst_o
);

    localparam int             CNT_W    = $clog2(SWITCH_GAP + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SWITCH_GAP - 1);

    state_t                 state;
    logic [7:0]             active;
    logic [7:0]             pending;
    logic [CNT_W-1:0]       cnt;
    logic                   rst_hold;
    logic                   act_wr;
    logic [7:0]             act_wr_dat;
    logic [IO_PADS-1:0]     oeb_reg;
    logic [STATUS_W-1:0]    status;
    logic                   in_range;
    logic                   run_ok;

    assign in_range = (32'(active) < NUM_PROJECTS);
    assign run_ok   = (state == ST_RUN) && in_range;

    always_comb begin
        status                   = '0;
        status[7:0]              = active;
        status[ST_BIT_SWITCHING] = (state == ST_DRAIN);
        status[ST_BIT_RANGE]     = ~in_range;
    end

    project_mux_regs #(
        .IO_PADS   (IO_PADS),
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .clk        (wb_clk_i),
        .reset_n    (wb_rstn_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .status     (status),
        .oeb_reg    (oeb_reg),
        .act_wr     (act_wr),
        .act_wr_dat (act_wr_dat)
    );

    // Switch sequencer: a new selection (or any selection while draining) restarts the gap
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state   <= ST_RUN;
            active  <= '0;
            pending <= '0;
            cnt     <= '0;
        end else if (act_wr && (state == ST_DRAIN || act_wr_dat != active)) begin
            state   <= ST_DRAIN;
            pending <= act_wr_dat;
            cnt     <= CNT_LOAD;
        end else if (state == ST_DRAIN) begin
            if (cnt == '0) begin
                active <= pending;
                state  <= ST_RUN;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Keeps every project in reset for one cycle after reset is released
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) rst_hold <= 1'b1;
        else            rst_hold <= 1'b0;
    end

    // Pad routing: only the active, in-range project sees pads while running
    always_comb begin
        io_out     = '0;
        io_oeb     = '1;
        proj_io_in = '0;
        proj_rst_o = '1;
        if (run_ok) begin
            io_oeb = oeb_reg;
            for (int k = 0; k < NUM_PROJECTS; k++) begin
                if (active == 8'(k)) begin
                    io_out                        = proj_io_out[k*IO_PADS +: IO_PADS];
                    proj_io_in[k*IO_PADS +: IO_PADS] = io_in;
                    proj_rst_o[k]                 = 1'b0;
                end
            end
        end
        if (!wb_rstn_i || rst_hold) proj_rst_o = '1;
    end

endmodule

// File: tb/tb_project_mux_ctrl.sv
`timescale 1ns/1ps
module tb_project_mux_ctrl;

    localparam int          NP   = 8;
    localparam int          IOP  = 38;
    localparam int          GAP  = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] HI_MASK = (32'd1 << (IOP - 32)) - 32'd1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]        sel = '0;
    logic [31:0]       adr = '0, dat_i = '0;
    logic              ack;
    logic [31:0]       dat_o;
    logic [IOP-1:0]    io_in = '0;
    logic [IOP-1:0]    io_out, io_oeb;
    logic [NP*IOP-1:0] proj_io_out;
    logic [NP*IOP-1:0] proj_io_in;
    logic [NP-1:0]     proj_rst;
    logic [IOP-1:0]    pat [NP];

    always #5 clk = ~clk;

    project_mux_ctrl #(
        .NUM_PROJECTS (NP), .IO_PADS (IOP), .BASE_ADDR (BASE), .SWITCH_GAP (GAP)
    ) dut (
        .wb_clk_i (clk), .wb_rstn_i (rstn),
        .wbs_stb_i (stb), .wbs_cyc_i (cyc), .wbs_we_i (we), .wbs_sel_i (sel),
        .wbs_adr_i (adr), .wbs_dat_i (dat_i), .wbs_ack_o (ack), .wbs_dat_o (dat_o),
        .io_in (io_in), .io_out (io_out), .io_oeb (io_oeb),
        .proj_io_out (proj_io_out), .proj_io_in (proj_io_in), .proj_rst_o (proj_rst)
    );

    always_comb begin
        proj_io_out = '0;
        for (int k = 0; k < NP; k++) proj_io_out[k*IOP +: IOP] = pat[k];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: register contents plus a time-stamped view of the switch
    logic [7:0]  m_req, m_active, m_pend;
    logic [31:0] m_lo, m_hi;
    bit          m_drain, m_hold;
    int          m_sw_edge, edge_n = 0;
    bit          chk_en = 1'b0;
    logic [31:0] sb [$];

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] r;
        r = {24'd0, m_active};
        r[8] = m_drain;
        r[9] = (int'(m_active) >= NP);
        return r;
    endfunction

    // Model update on every rising edge, from the bench's own bus drive
    initial begin
        logic [7:0]  off;
        logic [31:0] rd;
        bit          act_w;
        forever begin
            @(posedge clk);
            edge_n++;
            act_w = 1'b0;
            if (!rstn) begin
                m_req = '0; m_lo = '1; m_hi = HI_MASK; m_active = '0; m_pend = '0;
                m_drain = 1'b0; m_hold = 1'b1; sb.delete(); chk_en = 1'b1;
            end else begin
                m_hold = 1'b0;
                if (cyc && stb && adr[31:8] == BASE[31:8]) begin
                    off = adr[7:0];
                    rd = '0;
                    if (!we) begin
                        case (off)
                            8'h00: rd = {24'd0, m_req};
                            8'h04: rd = m_lo;
                            8'h08: rd = m_hi;
                            8'h0C: rd = m_status();
                            default: rd = '0;
                        endcase
                    end else begin
                        case (off)
                            8'h00: if (sel[0]) begin m_req = dat_i[7:0]; act_w = 1'b1; end
                            8'h04: m_lo = lanes(m_lo, dat_i, sel);
                            8'h08: m_hi = lanes(m_hi, dat_i, sel) & HI_MASK;
                            default: ;
                        endcase
                    end
                    sb.push_back(rd);
                end
                if (act_w && (m_drain || m_req != m_active)) begin
                    m_drain = 1'b1; m_sw_edge = edge_n; m_pend = m_req;
                end else if (m_drain && edge_n == m_sw_edge + GAP) begin
                    m_active = m_pend; m_drain = 1'b0;
                end
            end
        end
    end

    // Monitor: every falling edge compare bus response and pad routing
    initial begin
        bit              exp_ack, run_ok;
        logic [31:0]     exp_dat;
        logic [IOP-1:0]  e_out, e_oeb;
        logic [NP-1:0]   e_rst;
        logic [NP*IOP-1:0] e_in;
        int              ai;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_ack = (sb.size() > 0);
                n_cmp++;
                if (ack !== exp_ack) begin
                    n_bad++;
                    $display("FAIL ack @%0t: got %b want %b", $time, ack, exp_ack);
                end
                if (exp_ack) begin
                    exp_dat = sb.pop_front();
                    if (ack === 1'b1) begin
                        n_cmp++;
                        if (dat_o !== exp_dat) begin
                            n_bad++;
                            $display("FAIL rdata @%0t: got %h want %h", $time, dat_o, exp_dat);
                        end
                    end
                end
                ai = int'(m_active);
                run_ok = !m_drain && ai < NP;
                e_out = '0; e_oeb = '1; e_rst = '1; e_in = '0;
                if (run_ok) begin
                    e_out = pat[ai];
                    e_oeb = {m_hi[IOP-33:0], m_lo};
                    e_rst[ai] = 1'b0;
                    e_in[ai*IOP +: IOP] = io_in;
                end
                if (m_hold || !rstn) e_rst = '1;
                n_cmp++;
                if (io_out !== e_out || io_oeb !== e_oeb || proj_rst !== e_rst || proj_io_in !== e_in) begin
                    n_bad++;
                    $display("FAIL pads @%0t: got out=%h oeb=%h rst=%h in=%h want out=%h oeb=%h rst=%h in=%h",
                             $time, io_out, io_oeb, proj_rst, proj_io_in, e_out, e_oeb, e_rst, e_in);
                end
            end
        end
    end

    // Pad and project traffic changes away from both clock edges
    initial begin
        logic [63:0] r64;
        for (int k = 0; k < NP; k++) begin
            r64 = {$urandom(), $urandom()};
            pat[k] = r64[IOP-1:0];
        end
        forever begin
            @(posedge clk);
            #2;
            r64 = {$urandom(), $urandom()};
            io_in = r64[IOP-1:0];
            if ($urandom_range(0, 7) == 0) begin
                r64 = {$urandom(), $urandom()};
                pat[$urandom_range(0, NP-1)] = r64[IOP-1:0];
            end
        end
    end

    task automatic bus(input logic [31:0] a, input bit w, input logic [3:0] s, input logic [31:0] d);
        @(negedge clk);
        adr = a; we = w; sel = s; dat_i = d; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        idle(2);
        bus(BASE + 32'h0C, 1'b0, 4'hF, '0);                  // status after reset
        bus(BASE + 32'h00, 1'b1, 4'h1, 32'd3);               // select project 3
        idle(6);
        bus(BASE + 32'h0C, 1'b0, 4'hF, '0);
        bus(BASE + 32'h00, 1'b0, 4'hF, '0);
        bus(BASE + 32'h04, 1'b1, 4'b0010, 32'h0000_FF00);    // byte1 only
        bus(BASE + 32'h04, 1'b0, 4'hF, '0);
        bus(BASE + 32'h04, 1'b1, 4'b0010, 32'h1234_5600);
        bus(BASE + 32'h04, 1'b0, 4'hF, '0);
        bus(BASE + 32'h08, 1'b1, 4'hF, 32'hFFFF_FFE5);
        bus(BASE + 32'h08, 1'b0, 4'hF, '0);
        bus(BASE + 32'h00, 1'b1, 4'h1, 32'd9);               // out of range
        idle(6);
        bus(BASE + 32'h0C, 1'b0, 4'hF, '0);
        bus(BASE + 32'h00, 1'b1, 4'h1, 32'd2);               // 2 then 5, restart gap
        bus(BASE + 32'h00, 1'b1, 4'h1, 32'd5);
        idle(6);
        bus(BASE + 32'h00, 1'b1, 4'h1, 32'd5);               // same value, no switch
        bus(BASE + 32'h00, 1'b1, 4'hE, 32'd1);               // byte0 not selected
        bus(BASE + 32'h0C, 1'b1, 4'hF, 32'hFFFF_FFFF);       // read-only
        bus(BASE + 32'h0C, 1'b0, 4'hF, '0);
        bus(BASE + 32'h40, 1'b0, 4'hF, '0);                  // unmapped, in bank
        bus(BASE + 32'h40, 1'b1, 4'hF, 32'hDEAD_BEEF);
        bus(BASE + 32'h100, 1'b0, 4'hF, '0);                 // outside bank
        bus(BASE - 32'h4, 1'b0, 4'hF, '0);
        bus(BASE + 32'h00, 1'b1, 4'h1, 32'd4);               // reset mid-switch
        idle(1);
        reset_pulse();
        idle(2);
        bus(BASE + 32'h0C, 1'b0, 4'hF, '0);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2: bus(BASE, 1'b1, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 11)));
                3:       bus(BASE + 32'h04, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom());
                4:       bus(BASE + 32'h08, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom());
                5:       bus(BASE + 32'h0C, $urandom_range(0, 1) == 1, 4'hF, $urandom());
                6: begin
                    a = BASE + 32'($urandom_range(0, 255));
                    bus(a, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom());
                end
                7: begin
                    a = BASE + 32'h100 + 32'($urandom_range(0, 4095));
                    bus(a, $urandom_range(0, 1) == 1, 4'hF, $urandom());
                end
                default: bus(BASE + 32'(4 * $urandom_range(0, 3)), 1'b0, 4'hF, '0);
            endcase
            idle($urandom_range(0, 5));
            if ($urandom_range(0, 59) == 0) reset_pulse();
        end
        idle(8);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d outstanding acks want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
